// File: rtl/sim_axi_frag_pkg.sv
// sim_axi_frag_pkg: shared AXI response codes, fragmenter FSM states and the beat address advance.
// Exports: RESP_* encodings, w_state_e, r_state_e, addr_next(addr, size).
package sim_axi_frag_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  // Align down to the beat size, then step one beat; callers truncate to their address width.
  function automatic logic [63:0] addr_next(input logic [63:0] addr, input logic [2:0] size);
    logic [63:0] step;
    step = 64'd1 << size;
    return (addr & ~(step - 64'd1)) + step;
  endfunction
endpackage

// File: rtl/axi_frag_beat_gen.sv
// axi_frag_beat_gen: per-direction burst context (addr/len/size/id), beat counter and last flag.
// Ports: load_i latches a new burst from addr_i/len_i/size_i/id_i; advance_i steps to the next beat;
// addr_o/size_o/id_o give the current beat, last_o is high on the final beat.
module axi_frag_beat_gen
  import sim_axi_frag_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  input  logic [ID_BITS-1:0]   id_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [2:0]           size_o,
  output logic [ID_BITS-1:0]   id_o,
  output logic                 last_o
);
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d, cnt_q, cnt_d;
  logic [2:0]           size_q, size_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  always_comb begin
    addr_d = load_i ? addr_i : advance_i ? ADDR_BITS'(addr_next(64'(addr_q), size_q)) : addr_q;
    cnt_d  = load_i ? 8'd0 : advance_i ? cnt_q + 8'd1 : cnt_q;
    len_d  = load_i ? len_i : len_q;
    size_d = load_i ? size_i : size_q;
    id_d   = load_i ? id_i : id_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      size_q <= '0;
      id_q   <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      size_q <= size_d;
      id_q   <= id_d;
    end
  end
  assign addr_o = addr_q;
  assign size_o = size_q;
  assign id_o   = id_q;
  assign last_o = cnt_q == len_q;
endmodule

// File: rtl/sim_axi_burst_fragmenter.sv
// sim_axi_burst_fragmenter: splits upstream AXI4 INCR bursts into single-beat downstream transactions.
// Ports: s_aw/s_w/s_b and s_ar/s_r are the upstream slave port; m_aw/m_w/m_b and m_ar/m_r are the
// single-beat master port (downstream len/last/burst are tied off by the integrator).
// Write and read engines are independent, one burst outstanding each.
module sim_axi_burst_fragmenter
  import sim_axi_frag_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5,
  parameter int STRB_BITS = DATA_BITS / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_aw_valid,
  input  logic [ADDR_BITS-1:0] s_aw_addr,
  input  logic [7:0]           s_aw_len,
  input  logic [2:0]           s_aw_size,
  input  logic [ID_BITS-1:0]   s_aw_id,
  output logic                 s_aw_ready,
  input  logic                 s_w_valid,
  input  logic [DATA_BITS-1:0] s_w_data,
  input  logic [STRB_BITS-1:0] s_w_strb,
  input  logic                 s_w_last,
  output logic                 s_w_ready,
  output logic                 s_b_valid,
  output logic [1:0]           s_b_resp,
  output logic [ID_BITS-1:0]   s_b_id,
  input  logic                 s_b_ready,
  input  logic                 s_ar_valid,
  input  logic [ADDR_BITS-1:0] s_ar_addr,
  input  logic [7:0]           s_ar_len,
  input  logic [2:0]           s_ar_size,
  input  logic [ID_BITS-1:0]   s_ar_id,
  output logic                 s_ar_ready,
  output logic                 s_r_valid,
  output logic [DATA_BITS-1:0] s_r_data,
  output logic [1:0]           s_r_resp,
  output logic                 s_r_last,
  output logic [ID_BITS-1:0]   s_r_id,
  input  logic                 s_r_ready,
  output logic                 m_aw_valid,
  output logic [ADDR_BITS-1:0] m_aw_addr,
  output logic [2:0]           m_aw_size,
  output logic [ID_BITS-1:0]   m_aw_id,
  input  logic                 m_aw_ready,
  output logic                 m_w_valid,
  output logic [DATA_BITS-1:0] m_w_data,
  output logic [STRB_BITS-1:0] m_w_strb,
  input  logic                 m_w_ready,
  input  logic                 m_b_valid,
  input  logic [1:0]           m_b_resp,
  output logic                 m_b_ready,
  output logic                 m_ar_valid,
  output logic [ADDR_BITS-1:0] m_ar_addr,
  output logic [2:0]           m_ar_size,
  output logic [ID_BITS-1:0]   m_ar_id,
  input  logic                 m_ar_ready,
  input  logic                 m_r_valid,
  input  logic [DATA_BITS-1:0] m_r_data,
  input  logic [1:0]           m_r_resp,
  output logic                 m_r_ready
);
  w_state_e           w_state_q, w_state_d;
  r_state_e           r_state_q, r_state_d;
  logic [1:0]         resp_acc_q, resp_acc_d;
  logic [ID_BITS-1:0] w_id, r_id;
  logic               w_last, r_last, w_load, w_adv, r_load, r_adv, w_data_en, r_data_en, b_hs;
  logic               unused;
  assign unused = s_w_last;
  assign w_data_en = !reset && w_state_q == W_DATA;
  assign r_data_en = !reset && r_state_q == R_DATA;
  assign w_load = s_aw_valid && s_aw_ready;
  assign b_hs   = m_b_valid && m_b_ready;
  assign w_adv  = b_hs && !w_last;
  assign r_load = s_ar_valid && s_ar_ready;
  assign r_adv  = s_r_valid && s_r_ready && !r_last;
  // Worst downstream response wins: the encodings are ordered by severity.
  assign resp_acc_d = w_load ? RESP_OKAY : (b_hs && m_b_resp > resp_acc_q) ? m_b_resp : resp_acc_q;
  axi_frag_beat_gen #(.ADDR_BITS(ADDR_BITS), .ID_BITS(ID_BITS)) u_w_beat (
    .clock, .reset, .load_i(w_load), .advance_i(w_adv),
    .addr_i(s_aw_addr), .len_i(s_aw_len), .size_i(s_aw_size), .id_i(s_aw_id),
    .addr_o(m_aw_addr), .size_o(m_aw_size), .id_o(w_id), .last_o(w_last)
  );
  axi_frag_beat_gen #(.ADDR_BITS(ADDR_BITS), .ID_BITS(ID_BITS)) u_r_beat (
    .clock, .reset, .load_i(r_load), .advance_i(r_adv),
    .addr_i(s_ar_addr), .len_i(s_ar_len), .size_i(s_ar_size), .id_i(s_ar_id),
    .addr_o(m_ar_addr), .size_o(m_ar_size), .id_o(r_id), .last_o(r_last)
  );
  assign m_aw_id  = w_id;
  assign s_b_id   = w_id;
  assign s_b_resp = resp_acc_q;
  assign m_ar_id  = r_id;
  assign s_r_id   = r_id;
  always_comb begin
    w_state_d  = w_state_q;
    s_aw_ready = !reset && w_state_q == W_IDLE;
    m_aw_valid = !reset && w_state_q == W_ADDR;
    m_w_valid  = w_data_en && s_w_valid;
    s_w_ready  = w_data_en && m_w_ready;
    m_w_data   = w_data_en ? s_w_data : '0;
    m_w_strb   = w_data_en ? s_w_strb : '0;
    m_b_ready  = !reset && w_state_q == W_RESP;
    s_b_valid  = !reset && w_state_q == W_BRESP;
    case (w_state_q)
      W_IDLE:  if (s_aw_valid) w_state_d = W_ADDR;
      W_ADDR:  if (m_aw_ready) w_state_d = W_DATA;
      W_DATA:  if (s_w_valid && m_w_ready) w_state_d = W_RESP;
      W_RESP:  if (m_b_valid) w_state_d = w_last ? W_BRESP : W_ADDR;
      W_BRESP: if (s_b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d  = r_state_q;
    s_ar_ready = !reset && r_state_q == R_IDLE;
    m_ar_valid = !reset && r_state_q == R_ADDR;
    s_r_valid  = r_data_en && m_r_valid;
    m_r_ready  = r_data_en && s_r_ready;
    s_r_data   = r_data_en ? m_r_data : '0;
    s_r_resp   = r_data_en ? m_r_resp : '0;
    s_r_last   = r_data_en && r_last;
    case (r_state_q)
      R_IDLE:  if (s_ar_valid) r_state_d = R_ADDR;
      R_ADDR:  if (m_ar_ready) r_state_d = R_DATA;
      R_DATA:  if (m_r_valid && s_r_ready) r_state_d = r_last ? R_IDLE : R_ADDR;
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    w_state_q  <= reset ? W_IDLE : w_state_d;
    r_state_q  <= reset ? R_IDLE : r_state_d;
    resp_acc_q <= reset ? RESP_OKAY : resp_acc_d;
  end
endmodule

// File: tb/tb_sim_axi_burst_fragmenter.sv
// tb_sim_axi_burst_fragmenter: directed burst table plus reset and concurrency sequences.
module tb_sim_axi_burst_fragmenter;
  localparam int LIM = 400;
  logic        clock = 1'b0;
  logic        reset;
  logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready, s_b_valid, s_b_ready;
  logic [31:0] s_aw_addr, s_ar_addr, m_aw_addr, m_ar_addr;
  logic [7:0]  s_aw_len, s_ar_len, s_w_strb, m_w_strb;
  logic [2:0]  s_aw_size, s_ar_size, m_aw_size, m_ar_size;
  logic [4:0]  s_aw_id, s_ar_id, s_b_id, s_r_id, m_aw_id, m_ar_id;
  logic [63:0] s_w_data, s_r_data, m_w_data, m_r_data;
  logic [1:0]  s_b_resp, s_r_resp, m_b_resp, m_r_resp;
  logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_last, s_r_ready;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  always #5 clock = ~clock;
  sim_axi_burst_fragmenter dut (
    .clock(clock), .reset(reset),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_id(s_aw_id), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_id(s_b_id), .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_id(s_ar_id), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_id(s_r_id), .s_r_ready(s_r_ready),
    .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_size(m_aw_size), .m_aw_id(m_aw_id),
    .m_aw_ready(m_aw_ready),
    .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_ready(m_w_ready),
    .m_b_valid(m_b_valid), .m_b_resp(m_b_resp), .m_b_ready(m_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_size(m_ar_size), .m_ar_id(m_ar_id),
    .m_ar_ready(m_ar_ready),
    .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_ready(m_r_ready)
  );
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [4:0]  id;
    int          err_beat;
    logic [1:0]  err_code;
    logic [31:0] a1;
    logic [31:0] alast;
    logic [1:0]  resp;
    bit          stall;
  } vec_t;
  vec_t        tab[10];
  int          checks = 0, errors = 0, cyc = 0;
  bit          w_stall = 0, r_stall = 0;
  int          err_beat = -1, b_idx = 0, mb_cyc = 0;
  logic [1:0]  err_code = 2'd0;
  logic [4:0]  wid = '0, rid = '0;
  logic [2:0]  wsize = '0, rsize = '0;
  logic [31:0] aw_log[$], ar_log[$];
  logic [71:0] w_log[$];
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, LIM);
  endtask
  // Downstream single-beat memory: B one cycle after each W, R one cycle after each AR.
  bit          b_pend = 0, r_pend = 0, aw_hold = 0, ar_hold = 0;
  logic [31:0] aw_hold_a, ar_hold_a;
  logic [63:0] r_val = '0;
  always begin
    @(negedge clock);
    m_aw_ready = w_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_w_ready  = w_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_ar_ready = r_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_b_valid  = b_pend;
    m_b_resp   = (b_idx == err_beat) ? err_code : 2'd0;
    m_r_valid  = r_pend;
    m_r_data   = r_val;
    m_r_resp   = r_val[3:2];
    #4;
    if (reset) begin
      b_pend = 0; r_pend = 0; aw_hold = 0; ar_hold = 0;
    end else begin
      if (aw_hold) chk("m_aw stable", {m_aw_valid, m_aw_addr}, {1'b1, aw_hold_a});
      if (ar_hold) chk("m_ar stable", {m_ar_valid, m_ar_addr}, {1'b1, ar_hold_a});
      aw_hold = m_aw_valid && !m_aw_ready; aw_hold_a = m_aw_addr;
      ar_hold = m_ar_valid && !m_ar_ready; ar_hold_a = m_ar_addr;
      if (m_aw_valid && m_aw_ready) begin
        aw_log.push_back(m_aw_addr);
        chk("m_aw id/size", {m_aw_id, m_aw_size}, {wid, wsize});
      end
      if (m_b_valid && m_b_ready) begin b_pend = 0; b_idx++; mb_cyc = cyc; end
      if (m_w_valid && m_w_ready) begin w_log.push_back({m_w_strb, m_w_data}); b_pend = 1; end
      if (m_r_valid && m_r_ready) r_pend = 0;
      if (m_ar_valid && m_ar_ready) begin
        ar_log.push_back(m_ar_addr);
        chk("m_ar id/size", {m_ar_id, m_ar_size}, {rid, rsize});
        r_pend = 1;
        r_val = {32'hCAFE0000, m_ar_addr};
      end
    end
  end
  task automatic do_write(input vec_t v, input int nw, input bit wait_b);
    int t;
    bit seen, hold;
    int bc;
    logic [1:0] pr;
    logic [4:0] pi;
    t = 0;
    do begin
      @(negedge clock);
      s_aw_valid = 1'b1; s_aw_addr = v.addr; s_aw_len = v.len; s_aw_size = v.size; s_aw_id = v.id;
      #4; t++;
    end while (!s_aw_ready && t < LIM);
    if (t >= LIM) timeout("s_aw handshake");
    @(negedge clock);
    s_aw_valid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      t = 0;
      do begin
        @(negedge clock);
        s_w_valid = v.stall ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        s_w_data  = 64'hBEEF_0000_0000_0000 + 64'(i);
        s_w_strb  = 8'(i + 1);
        #4; t++;
      end while (!(s_w_valid && s_w_ready) && t < LIM);
      if (t >= LIM) begin timeout("s_w handshake"); break; end
    end
    if (!wait_b) return;
    @(negedge clock);
    s_w_valid = 1'b0;
    t = 0; seen = 0; hold = 0; bc = 0;
    do begin
      @(negedge clock);
      s_b_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #4; t++;
      if (hold) chk("s_b stable", {s_b_valid, s_b_resp, s_b_id}, {1'b1, pr, pi});
      hold = s_b_valid && !s_b_ready; pr = s_b_resp; pi = s_b_id;
      if (s_b_valid && !seen) begin seen = 1; bc = cyc; end
    end while (!(s_b_valid && s_b_ready) && t < LIM);
    if (t >= LIM) timeout("s_b handshake");
    else begin
      chk("s_b_resp", s_b_resp, v.resp);
      chk("s_b_id", s_b_id, v.id);
      chk("s_b latency", bc, mb_cyc + 1);
    end
    @(negedge clock);
    s_b_ready = 1'b0;
  endtask
  task automatic do_read(input vec_t v);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      s_ar_valid = 1'b1; s_ar_addr = v.addr; s_ar_len = v.len; s_ar_size = v.size; s_ar_id = v.id;
      #4; t++;
    end while (!s_ar_ready && t < LIM);
    if (t >= LIM) timeout("s_ar handshake");
    @(negedge clock);
    s_ar_valid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      t = 0;
      do begin
        @(negedge clock);
        s_r_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        #4; t++;
      end while (!(s_r_valid && s_r_ready) && t < LIM);
      if (t >= LIM) begin timeout("s_r handshake"); break; end
      chk("s_r_data", s_r_data, {32'hCAFE0000, ar_log[i]});
      chk("s_r_resp", s_r_resp, ar_log[i][3:2]);
      chk("s_r_last", s_r_last, i == int'(v.len));
      if (i == int'(v.len)) chk("s_r_id", s_r_id, v.id);
    end
    @(negedge clock);
    s_r_ready = 1'b0;
  endtask
  task automatic check_addrs(input string tag, input logic [31:0] lg[$], input vec_t v);
    chk({tag, " beats"}, lg.size(), int'(v.len) + 1);
    if (lg.size() > 0) begin
      chk({tag, " addr0"}, lg[0], v.addr);
      chk({tag, " addr_last"}, lg[lg.size()-1], v.alast);
    end
    if (v.len > 0 && lg.size() > 1) chk({tag, " addr1"}, lg[1], v.a1);
  endtask
  task automatic run_vec(input vec_t v);
    if (v.rd) begin
      ar_log.delete();
      r_stall = v.stall; rid = v.id; rsize = v.size;
      do_read(v);
      check_addrs("m_ar", ar_log, v);
    end else begin
      aw_log.delete(); w_log.delete();
      w_stall = v.stall; wid = v.id; wsize = v.size;
      err_beat = v.err_beat; err_code = v.err_code; b_idx = 0;
      do_write(v, int'(v.len) + 1, 1'b1);
      check_addrs("m_aw", aw_log, v);
      for (int i = 0; i < w_log.size(); i++)
        chk("m_w beat", w_log[i], {8'(i + 1), 64'hBEEF_0000_0000_0000 + 64'(i)});
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    //          rd   addr          len     size  id     eb  ec     a1            alast         resp   stall
    tab[0] = '{1'b0, 32'h0000_1000, 8'd0,   3'd3, 5'd1,  -1, 2'd0, 32'h0000_0000, 32'h0000_1000, 2'd0, 1'b0};
    tab[1] = '{1'b1, 32'h0000_2000, 8'd255, 3'd3, 5'd7,  -1, 2'd0, 32'h0000_2008, 32'h0000_27F8, 2'd0, 1'b0};
    tab[2] = '{1'b1, 32'h0000_1003, 8'd2,   3'd2, 5'd2,  -1, 2'd0, 32'h0000_1004, 32'h0000_1008, 2'd0, 1'b0};
    tab[3] = '{1'b0, 32'h0000_3000, 8'd3,   3'd3, 5'd9,   1, 2'd2, 32'h0000_3008, 32'h0000_3018, 2'd2, 1'b0};
    tab[4] = '{1'b0, 32'h0000_4001, 8'd1,   3'd0, 5'd4,   1, 2'd1, 32'h0000_4002, 32'h0000_4002, 2'd1, 1'b0};
    tab[5] = '{1'b1, 32'hFFFF_FFFC, 8'd1,   3'd2, 5'd5,  -1, 2'd0, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0};
    tab[6] = '{1'b0, 32'h0000_5010, 8'd1,   3'd7, 5'd6,   0, 2'd3, 32'h0000_5080, 32'h0000_5080, 2'd3, 1'b0};
    tab[7] = '{1'b0, 32'h0000_7004, 8'd5,   3'd2, 5'd10,  4, 2'd2, 32'h0000_7008, 32'h0000_7018, 2'd2, 1'b1};
    tab[8] = '{1'b1, 32'h0000_8000, 8'd9,   3'd3, 5'd11, -1, 2'd0, 32'h0000_8008, 32'h0000_8048, 2'd0, 1'b1};
    tab[9] = '{1'b0, 32'h0000_6000, 8'd3,   3'd3, 5'd12, -1, 2'd0, 32'h0000_6008, 32'h0000_6018, 2'd0, 1'b0};
    reset = 1'b1;
    s_aw_valid = 0; s_aw_addr = '0; s_aw_len = '0; s_aw_size = '0; s_aw_id = '0;
    s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 1'b1; s_b_ready = 0;
    s_ar_valid = 0; s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0; s_ar_id = '0; s_r_ready = 0;
    repeat (2) @(negedge clock);
    #4;
    chk("reset handshakes", {s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid,
        m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 10'd0);
    chk("reset payloads", {m_aw_addr, m_ar_addr, s_b_id, s_r_id, s_r_data}, '0);
    @(negedge clock);
    reset = 1'b0;
    #4;
    chk("idle readies", {s_aw_ready, s_ar_ready, m_aw_valid, m_ar_valid, s_b_valid}, 5'b11000);
    for (int i = 0; i < 7; i++) run_vec(tab[i]);
    fork
      run_vec(tab[7]);
      run_vec(tab[8]);
    join
    aw_log.delete(); w_log.delete();
    w_stall = 0; wid = tab[9].id; wsize = tab[9].size; err_beat = -1; b_idx = 0;
    do_write(tab[9], 2, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    s_w_valid = 1'b0;
    #4;
    chk("mid-burst reset handshakes", {s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid,
        m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 10'd0);
    chk("beats before reset", aw_log.size(), 2);
    @(negedge clock);
    reset = 1'b0;
    #4;
    chk("after reset idle", {s_aw_ready, s_ar_ready, m_aw_valid, s_b_valid, m_aw_addr, s_b_id},
        {4'b1100, 32'h0, 5'h0});
    run_vec(tab[3]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
